// File: rtl/xgmii_tx_encoder_pkg.sv
// Shared definitions for the XGMII transmit encoder.
//   - XGMII control code bytes and the derived full-word constants
//   - FSM state encoding used by xgmii_tx_encoder
package xgmii_tx_encoder_pkg;

  localparam logic [7:0] CodeIdle     = 8'h07;
  localparam logic [7:0] CodeStart    = 8'hFB;
  localparam logic [7:0] CodeTerm     = 8'hFD;
  localparam logic [7:0] CodeError    = 8'hFE;
  localparam logic [7:0] CodePreamble = 8'h55;
  localparam logic [7:0] CodeSfd      = 8'hD5;

  localparam logic [63:0] IdleWord  = {8{CodeIdle}};
  localparam logic [63:0] ErrorWord = {8{CodeError}};
  localparam logic [63:0] StartWord = {CodeStart, {7{CodePreamble}}};

  // Lane 0 is the MSB byte, so txc bit 7 flags lane 0.
  localparam logic [7:0] TxcAllCtrl = 8'hFF;
  localparam logic [7:0] TxcAllData = 8'h00;
  localparam logic [7:0] TxcStart   = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StTerm,
    StDrop,
    StIfg
  } state_e;

endpackage

// File: rtl/xgmii_tx_encoder.sv
// AXI-stream to 64-bit XGMII transmit encoder.
//
// Accepts frames (destination MAC through FCS) on a 64-bit AXI-stream input and
// emits start + preamble + SFD, the frame bytes, a terminate code and an
// inter-frame gap of P_IFG_WORDS all-idle words. Because the start word carries
// seven preamble bytes, the SFD occupies lane 0 of the first data word and the
// whole frame is shifted by one byte; the trailing byte of each beat is carried
// into lane 0 of the next word. An underrun mid-frame emits an error word and
// the rest of the frame is drained silently.
//
// Ports:
//   i_clk          single clock for both sides
//   i_rst          synchronous active-low reset
//   s_axis_tdata   frame bytes, byte 0 in [63:56]
//   s_axis_tkeep   valid-byte mask, bit 7 qualifies byte 0
//   s_axis_tlast   last beat of frame
//   s_axis_tvalid  beat valid
//   s_axis_tready  beat accepted when high with tvalid (registered)
//   o_xgmii_txd    XGMII data, lane 0 in [63:56] (registered)
//   o_xgmii_txc    XGMII control flags, bit 7 = lane 0 (registered)
//   o_frame_cnt    frames completed without error, wrapping (registered)
module xgmii_tx_encoder
  import xgmii_tx_encoder_pkg::*;
#(
  parameter int unsigned P_IFG_WORDS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] o_xgmii_txd,
  output logic [7:0]  o_xgmii_txc,
  output logic [15:0] o_frame_cnt
);

  localparam logic [3:0] IfgInit = 4'(P_IFG_WORDS);

  // Number of leading ones in keep, counted from bit 7; anything after the
  // first zero is ignored.
  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    logic [3:0] cnt;
    logic       stop;
    cnt  = 4'd0;
    stop = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!stop && keep[i]) begin
        cnt = cnt + 4'd1;
      end else begin
        stop = 1'b1;
      end
    end
    return cnt;
  endfunction

  state_e      state_q, state_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        tready_q, tready_d;
  logic [7:0]  carry_q, carry_d;
  logic        sfd_q, sfd_d;          // next data word starts with the SFD
  logic        term_byte_q, term_byte_d;  // TERM word still owes byte 7 (k=8)
  logic [3:0]  ifg_cnt_q, ifg_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [3:0]  keep_len;
  logic [7:0]  lead_byte;

  assign keep_len  = keep_count(s_axis_tkeep);
  assign lead_byte = sfd_q ? CodeSfd : carry_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      txd_q       <= IdleWord;
      txc_q       <= TxcAllCtrl;
      tready_q    <= 1'b0;
      carry_q     <= 8'h00;
      sfd_q       <= 1'b0;
      term_byte_q <= 1'b0;
      ifg_cnt_q   <= 4'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      tready_q    <= tready_d;
      carry_q     <= carry_d;
      sfd_q       <= sfd_d;
      term_byte_q <= term_byte_d;
      ifg_cnt_q   <= ifg_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    sfd_d       = sfd_q;
    term_byte_d = term_byte_q;
    ifg_cnt_d   = ifg_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StData;
        sfd_d   = 1'b1;
      end
      StData: begin
        if (!s_axis_tvalid) begin
          state_d = StDrop;
        end else begin
          carry_d = s_axis_tdata[7:0];
          sfd_d   = 1'b0;
          if (s_axis_tlast) begin
            if (keep_len <= 4'd6) begin
              state_d   = StIfg;
              ifg_cnt_d = IfgInit;
            end else begin
              state_d     = StTerm;
              term_byte_d = (keep_len == 4'd8);
            end
          end
        end
      end
      StTerm: begin
        state_d   = StIfg;
        ifg_cnt_d = IfgInit;
      end
      StDrop: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d   = StIfg;
          ifg_cnt_d = IfgInit;
        end
      end
      StIfg: begin
        // Leaving straight to START keeps the gap at exactly P_IFG_WORDS
        // when the next frame is already waiting.
        if (ifg_cnt_q <= 4'd1) begin
          state_d = s_axis_tvalid ? StStart : StIdle;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic (values registered on the next edge)
  always_comb begin
    txd_d       = IdleWord;
    txc_d       = TxcAllCtrl;
    frame_cnt_d = frame_cnt_q;
    tready_d    = (state_d == StData) || (state_d == StDrop);

    unique case (state_q)
      StIdle: begin
        txd_d = IdleWord;
        txc_d = TxcAllCtrl;
      end
      StStart: begin
        txd_d = StartWord;
        txc_d = TxcStart;
      end
      StData: begin
        if (!s_axis_tvalid) begin
          txd_d = ErrorWord;
          txc_d = TxcAllCtrl;
        end else begin
          txd_d = {lead_byte, s_axis_tdata[63:8]};
          txc_d = TxcAllData;
          if (s_axis_tlast && keep_len <= 4'd6) begin
            // Terminate lands in lane k+1, idle fill after it.
            for (int i = 1; i < 8; i++) begin
              if (i == int'(keep_len) + 1) begin
                txd_d[63-8*i -: 8] = CodeTerm;
                txc_d[7-i]         = 1'b1;
              end else if (i > int'(keep_len) + 1) begin
                txd_d[63-8*i -: 8] = CodeIdle;
                txc_d[7-i]         = 1'b1;
              end
            end
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      StTerm: begin
        if (term_byte_q) begin
          txd_d = {carry_q, CodeTerm, {6{CodeIdle}}};
          txc_d = 8'h7F;
        end else begin
          txd_d = {CodeTerm, {7{CodeIdle}}};
          txc_d = TxcAllCtrl;
        end
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      StDrop, StIfg: begin
        txd_d = IdleWord;
        txc_d = TxcAllCtrl;
      end
      default: begin
        txd_d = IdleWord;
        txc_d = TxcAllCtrl;
      end
    endcase
  end

  assign s_axis_tready = tready_q;
  assign o_xgmii_txd   = txd_q;
  assign o_xgmii_txc   = txc_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
module tb_xgmii_tx_encoder;

  localparam logic [63:0] Idle  = 64'h0707070707070707;
  localparam logic [63:0] Start = 64'hFB55555555555555;
  localparam logic [63:0] Beat  = 64'h1122334455667788;
  localparam logic [63:0] Mid   = 64'h8811223344556677;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        sel;  // 0: dut0 (IFG 2), 1: dut1 (IFG 1)

  logic        tready0, tready1;
  logic [63:0] txd0, txd1;
  logic [7:0]  txc0, txc1;
  logic [15:0] cnt0, cnt1;

  logic        tready;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic [15:0] cnt;

  assign tready = sel ? tready1 : tready0;
  assign txd    = sel ? txd1 : txd0;
  assign txc    = sel ? txc1 : txc0;
  assign cnt    = sel ? cnt1 : cnt0;

  xgmii_tx_encoder #(.P_IFG_WORDS(2)) u_dut0 (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid & ~sel),
    .s_axis_tready (tready0),
    .o_xgmii_txd   (txd0),
    .o_xgmii_txc   (txc0),
    .o_frame_cnt   (cnt0)
  );

  xgmii_tx_encoder #(.P_IFG_WORDS(1)) u_dut1 (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid & sel),
    .s_axis_tready (tready1),
    .o_xgmii_txd   (txd1),
    .o_xgmii_txc   (txc1),
    .o_frame_cnt   (cnt1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt0 = 16'd0;
  logic [15:0] exp_cnt1 = 16'd0;

  logic [63:0] lg_txd[$];
  logic [7:0]  lg_txc[$];
  logic [15:0] lg_cnt[$];

  always @(negedge clk) begin
    lg_txd.push_back(txd);
    lg_txc.push_back(txc);
    lg_cnt.push_back(cnt);
  end

  task automatic clear_log();
    lg_txd.delete();
    lg_txc.delete();
    lg_cnt.delete();
  endtask

  function automatic int find_start(input int from);
    for (int i = from; i < lg_txd.size(); i++) begin
      if (lg_txd[i] === Start && lg_txc[i] === 8'h80) return i;
    end
    return -1;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n      = 0;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    while (tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: tready stayed %b, want 1", tready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int nbeats, input logic [7:0] last_keep, input bit hold);
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(Beat, (b == nbeats - 1) ? last_keep : 8'hFF, b == nbeats - 1);
    end
    if (!hold) begin
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (txd0 !== Idle) begin
      n_bad++; $display("FAIL reset_txd: got %h want %h", txd0, Idle);
    end
    n_cmp++;
    if (txc0 !== 8'hFF) begin
      n_bad++; $display("FAIL reset_txc: got %h want ff", txc0);
    end
    n_cmp++;
    if (tready0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_tready: got %b want 0", tready0);
    end
    n_cmp++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", cnt0, cnt1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (txd0 !== Idle || tready0 !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %h/%b want %h/0", txd0, tready0, Idle);
    end
  endtask

  task automatic test_full_frame();
    int s;
    clear_log();
    send_frame(10, 8'hFF, 1'b0);
    repeat (8) @(negedge clk);
    s = find_start(0);
    n_cmp++;
    if (s < 0 || s + 13 >= lg_txd.size()) begin
      n_bad++; $display("FAIL full_start: got index %0d want start word in log", s);
    end else begin
      n_cmp++;
      if (lg_txd[s+1] !== 64'hD511223344556677 || lg_txc[s+1] !== 8'h00) begin
        n_bad++;
        $display("FAIL full_sfd_word: got %h/%h want d511223344556677/00", lg_txd[s+1], lg_txc[s+1]);
      end
      for (int i = 2; i <= 10; i++) begin
        n_cmp++;
        if (lg_txd[s+i] !== Mid || lg_txc[s+i] !== 8'h00) begin
          n_bad++;
          $display("FAIL full_data_%0d: got %h/%h want %h/00", i, lg_txd[s+i], lg_txc[s+i], Mid);
        end
      end
      n_cmp++;
      if (lg_txd[s+11] !== 64'h88FD070707070707 || lg_txc[s+11] !== 8'h7F) begin
        n_bad++;
        $display("FAIL full_term: got %h/%h want 88fd070707070707/7f", lg_txd[s+11], lg_txc[s+11]);
      end
      n_cmp++;
      if (lg_cnt[s+10] !== exp_cnt0 || lg_cnt[s+11] !== exp_cnt0 + 16'd1) begin
        n_bad++;
        $display("FAIL full_cnt_timing: got %h,%h want %h,%h", lg_cnt[s+10], lg_cnt[s+11],
                 exp_cnt0, exp_cnt0 + 16'd1);
      end
      for (int i = 12; i <= 13; i++) begin
        n_cmp++;
        if (lg_txd[s+i] !== Idle || lg_txc[s+i] !== 8'hFF) begin
          n_bad++; $display("FAIL full_ifg_%0d: got %h/%h want %h/ff", i, lg_txd[s+i], lg_txc[s+i], Idle);
        end
      end
    end
    exp_cnt0 = exp_cnt0 + 16'd1;
    n_cmp++;
    if (cnt0 !== exp_cnt0) begin
      n_bad++; $display("FAIL full_cnt: got %h want %h", cnt0, exp_cnt0);
    end
  endtask

  task automatic test_keep_sweep();
    logic [7:0]  keeps [8];
    logic [63:0] words [8];
    logic [7:0]  ctls  [8];
    int          s;
    keeps = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hB0};
    words = '{64'h8811FD0707070707, 64'h881122FD07070707, 64'h88112233FD070707,
              64'h8811223344FD0707, 64'h881122334455FD07, 64'h88112233445566FD,
              64'h8811223344556677, 64'h8811FD0707070707};
    ctls  = '{8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h3F};
    for (int j = 0; j < 8; j++) begin
      clear_log();
      send_frame(10, keeps[j], 1'b0);
      repeat (8) @(negedge clk);
      s = find_start(0);
      n_cmp++;
      if (s < 0 || s + 12 >= lg_txd.size()) begin
        n_bad++; $display("FAIL sweep_start_%h: got index %0d want start word", keeps[j], s);
      end else begin
        n_cmp++;
        if (lg_txd[s+10] !== words[j] || lg_txc[s+10] !== ctls[j]) begin
          n_bad++;
          $display("FAIL sweep_last_%h: got %h/%h want %h/%h", keeps[j], lg_txd[s+10],
                   lg_txc[s+10], words[j], ctls[j]);
        end
        if (keeps[j] == 8'hFE) begin
          n_cmp++;
          if (lg_txd[s+11] !== 64'hFD07070707070707 || lg_txc[s+11] !== 8'hFF) begin
            n_bad++;
            $display("FAIL sweep_term_fe: got %h/%h want fd07070707070707/ff", lg_txd[s+11],
                     lg_txc[s+11]);
          end
        end else begin
          n_cmp++;
          if (lg_txd[s+11] !== Idle || lg_txc[s+11] !== 8'hFF) begin
            n_bad++;
            $display("FAIL sweep_ifg_%h: got %h/%h want %h/ff", keeps[j], lg_txd[s+11],
                     lg_txc[s+11], Idle);
          end
        end
      end
      exp_cnt0 = exp_cnt0 + 16'd1;
      n_cmp++;
      if (cnt0 !== exp_cnt0) begin
        n_bad++; $display("FAIL sweep_cnt_%h: got %h want %h", keeps[j], cnt0, exp_cnt0);
      end
    end
  endtask

  task automatic test_single_beat();
    int s;
    clear_log();
    send_frame(1, 8'hF0, 1'b0);
    repeat (6) @(negedge clk);
    s = find_start(0);
    n_cmp++;
    if (s < 0 || s + 3 >= lg_txd.size()) begin
      n_bad++; $display("FAIL single_start: got index %0d want start word", s);
    end else begin
      n_cmp++;
      if (lg_txd[s+1] !== 64'hD511223344FD0707 || lg_txc[s+1] !== 8'h07) begin
        n_bad++;
        $display("FAIL single_word: got %h/%h want d511223344fd0707/07", lg_txd[s+1], lg_txc[s+1]);
      end
      n_cmp++;
      if (lg_txd[s+2] !== Idle || lg_txd[s+3] !== Idle) begin
        n_bad++; $display("FAIL single_ifg: got %h,%h want idle", lg_txd[s+2], lg_txd[s+3]);
      end
    end
    exp_cnt0 = exp_cnt0 + 16'd1;
    n_cmp++;
    if (cnt0 !== exp_cnt0) begin
      n_bad++; $display("FAIL single_cnt: got %h want %h", cnt0, exp_cnt0);
    end
  endtask

  task automatic test_underrun();
    int s;
    int nonidle;
    clear_log();
    for (int b = 1; b <= 4; b++) drive_beat(Beat, 8'hFF, 1'b0);
    tvalid = 1'b0;
    repeat (3) @(negedge clk);
    for (int b = 5; b <= 10; b++) drive_beat(Beat, 8'hFF, b == 10);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (6) @(negedge clk);
    s = find_start(0);
    n_cmp++;
    if (s < 0 || s + 6 >= lg_txd.size()) begin
      n_bad++; $display("FAIL underrun_start: got index %0d want start word", s);
    end else begin
      n_cmp++;
      if (lg_txd[s+1] !== 64'hD511223344556677 || lg_txd[s+4] !== Mid) begin
        n_bad++; $display("FAIL underrun_data: got %h,%h want d511223344556677,%h",
                          lg_txd[s+1], lg_txd[s+4], Mid);
      end
      n_cmp++;
      if (lg_txd[s+5] !== 64'hFEFEFEFEFEFEFEFE || lg_txc[s+5] !== 8'hFF) begin
        n_bad++;
        $display("FAIL underrun_error: got %h/%h want fefefefefefefefe/ff", lg_txd[s+5], lg_txc[s+5]);
      end
      nonidle = 0;
      for (int i = s + 6; i < lg_txd.size(); i++) begin
        if (lg_txd[i] !== Idle || lg_txc[i] !== 8'hFF) nonidle++;
      end
      n_cmp++;
      if (nonidle != 0) begin
        n_bad++; $display("FAIL underrun_drain: got %0d non-idle words want 0", nonidle);
      end
    end
    n_cmp++;
    if (cnt0 !== exp_cnt0) begin
      n_bad++; $display("FAIL underrun_cnt: got %h want %h", cnt0, exp_cnt0);
    end
    n_cmp++;
    if (tready0 !== 1'b0) begin
      n_bad++; $display("FAIL underrun_tready: got %b want 0", tready0);
    end
  endtask

  task automatic test_back_to_back(input bit which);
    int s;
    int p;
    int s2;
    p   = which ? 1 : 2;
    sel = which;
    @(negedge clk);
    clear_log();
    send_frame(2, 8'hF0, 1'b1);
    send_frame(2, 8'hF0, 1'b0);
    repeat (10) @(negedge clk);
    s = find_start(0);
    n_cmp++;
    if (s < 0 || s + 5 + p >= lg_txd.size()) begin
      n_bad++; $display("FAIL b2b_start_p%0d: got index %0d want start word", p, s);
    end else begin
      n_cmp++;
      if (lg_txd[s+2] !== 64'h8811223344FD0707 || lg_txc[s+2] !== 8'h07) begin
        n_bad++;
        $display("FAIL b2b_term_p%0d: got %h/%h want 8811223344fd0707/07", p, lg_txd[s+2], lg_txc[s+2]);
      end
      for (int i = 0; i < p; i++) begin
        n_cmp++;
        if (lg_txd[s+3+i] !== Idle || lg_txc[s+3+i] !== 8'hFF) begin
          n_bad++; $display("FAIL b2b_gap_p%0d_%0d: got %h want %h", p, i, lg_txd[s+3+i], Idle);
        end
      end
      s2 = find_start(s + 1);
      n_cmp++;
      if (s2 != s + 3 + p) begin
        n_bad++; $display("FAIL b2b_next_start_p%0d: got offset %0d want %0d", p, s2 - s, 3 + p);
      end
      n_cmp++;
      if (lg_txd[s+5+p] !== 64'h8811223344FD0707) begin
        n_bad++; $display("FAIL b2b_term2_p%0d: got %h want 8811223344fd0707", p, lg_txd[s+5+p]);
      end
    end
    if (which) exp_cnt1 = exp_cnt1 + 16'd2;
    else       exp_cnt0 = exp_cnt0 + 16'd2;
    n_cmp++;
    if (cnt !== (which ? exp_cnt1 : exp_cnt0)) begin
      n_bad++; $display("FAIL b2b_cnt_p%0d: got %h want %h", p, cnt, which ? exp_cnt1 : exp_cnt0);
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int s;
    for (int b = 1; b <= 4; b++) drive_beat(Beat, 8'hFF, 1'b0);
    tdata  = Beat;
    tkeep  = 8'hFF;
    tlast  = 1'b0;
    tvalid = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (txd0 !== Idle || txc0 !== 8'hFF) begin
      n_bad++; $display("FAIL midreset_out: got %h/%h want %h/ff", txd0, txc0, Idle);
    end
    n_cmp++;
    if (tready0 !== 1'b0) begin
      n_bad++; $display("FAIL midreset_tready: got %b want 0", tready0);
    end
    n_cmp++;
    if (cnt0 !== 16'd0) begin
      n_bad++; $display("FAIL midreset_cnt: got %h want 0", cnt0);
    end
    rst_n  = 1'b1;
    tvalid = 1'b0;
    exp_cnt0 = 16'd0;
    @(negedge clk);
    n_cmp++;
    if (txd0 !== Idle) begin
      n_bad++; $display("FAIL midreset_post: got %h want %h", txd0, Idle);
    end
    clear_log();
    send_frame(1, 8'hF0, 1'b0);
    repeat (6) @(negedge clk);
    s = find_start(0);
    n_cmp++;
    if (s < 0 || s + 1 >= lg_txd.size() || lg_txd[s+1] !== 64'hD511223344FD0707) begin
      n_bad++; $display("FAIL midreset_next_frame: start index %0d, want d511223344fd0707 after start", s);
    end
    exp_cnt0 = exp_cnt0 + 16'd1;
    n_cmp++;
    if (cnt0 !== exp_cnt0) begin
      n_bad++; $display("FAIL midreset_next_cnt: got %h want %h", cnt0, exp_cnt0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel    = 1'b0;
    rst_n  = 1'b0;
    tdata  = '0;
    tkeep  = '0;
    tlast  = 1'b0;
    tvalid = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_keep_sweep();
    test_single_beat();
    test_underrun();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
